spi_master_cfg: RTL and testbench

Parametrised SPI master that supersedes the fixed 32-bit free-running shifter. Each transfer is started by a start/busy/done handshake and uses a programmable frame width, clock divider, per-transfer CPOL/CPHA mode and one of NUM_CS chip selects. It sits between the on-chip control logic and off-chip SPI peripherals, and returns the received word on completion.

---
 rtl/spi_master_cfg.sv | 164 ++++++++++++++++
 tb/tb_spi_master_cfg.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// SPI master with start/busy/done handshake, programmable frame width, divider, CPOL/CPHA and chip select.
// Define SPI_MASTER_LSB_FIRST_EN to let lsb_first pick the bit order; otherwise frames are always MSB first.
module spi_master_cfg #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2*DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [EDGE_W-1:0] r_edge;
  logic [EDGE_W-1:0] w_edge_nxt;
  logic              r_cpha;
  logic              r_lsb;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;
  logic [NUM_CS-1:0] r_cs_n;
  logic [NUM_CS-1:0] w_cs_dec;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rx_data;
  logic [DATA_W-1:0] w_tx_shift;
  logic [DATA_W-1:0] w_rx_shift;
  logic              w_lsb_in;
  logic              w_accept;
  logic              w_tick;
  logic              w_edge_fire;
  logic              w_last_edge;
  logic              w_leading;
  logic              w_sample;
  logic              w_drive;
  logic              w_finish;

  function automatic logic first_bit(input logic [DATA_W-1:0] word, input logic lsb);
    return lsb ? word[0] : word[DATA_W-1];
  endfunction

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_lsb_in = lsb_first;
`else
  assign w_lsb_in = lsb_first & 1'b0;
`endif

  // An out-of-range index decodes to no active line; the transfer still runs.
  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) w_cs_dec[i] = 1'b0;
    end
  end

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_tick      = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_edge_nxt  = r_edge + 1'b1;
  assign w_edge_fire = ((r_state == S_SETUP) || (r_state == S_SHIFT)) && w_tick;
  assign w_last_edge = (w_edge_nxt == EDGE_W'(2*DATA_W));
  assign w_leading   = w_edge_nxt[0];
  assign w_sample    = w_edge_fire && (r_cpha ? !w_leading : w_leading);
  // CPHA=1 re-drives bit 0 on the first leading edge, so only later leading edges advance the shifter.
  assign w_drive     = w_edge_fire && (r_cpha ? (w_leading && (r_edge != '0))
                                              : (!w_leading && !w_last_edge));
  assign w_finish    = (r_state == S_HOLD) && w_tick;

  assign w_tx_shift  = r_lsb ? (r_tx >> 1) : (r_tx << 1);
  assign w_rx_shift  = r_lsb ? {spi_miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], spi_miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)                 w_state_nxt = S_SETUP;
      S_SETUP: if (w_tick)                w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_tick && w_last_edge) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_tick)                w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_edge    <= '0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs_n    <= '1;
      r_rx_data <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt  <= '0;
        r_edge <= '0;
        r_cpha <= cpha;
        r_lsb  <= w_lsb_in;
        r_sclk <= cpol;
        r_mosi <= first_bit(tx_data, w_lsb_in);
        r_busy <= 1'b1;
        r_cs_n <= w_cs_dec;
      end else if (r_state == S_IDLE) begin
        r_sclk <= cpol;
      end else begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_edge_fire) begin
          r_edge <= w_edge_nxt;
          r_sclk <= ~r_sclk;
        end
        if (w_drive) r_mosi <= first_bit(w_tx_shift, r_lsb);
        if (w_finish) begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_cs_n    <= '1;
          r_rx_data <= r_rx;
        end
      end
    end
  end

  // Shift registers carry data only; the FSM decides when their contents matter.
  always_ff @(posedge clk) begin
    if (w_accept)     r_tx <= tx_data;
    else if (w_drive) r_tx <= w_tx_shift;
    if (w_sample)     r_rx <= w_rx_shift;
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_data  = r_rx_data;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboard bench for spi_master_cfg: a bit-level SPI slave model feeds MISO and records MOSI.
module tb_spi_master_cfg;
  localparam int DW = 8;
  localparam int CD = 2;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] wire_w;
    logic       first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] tx_data;
  logic [1:0] cs_sel;
  logic       cpol, cpha, lsb_first;
  logic       busy, done;
  logic [7:0] rx_data;
  logic       spi_clk, spi_mosi, spi_miso;
  logic [3:0] spi_cs_n;

  logic       start3;
  logic [1:0] cs_sel3;
  logic       busy3, done3, sclk3, mosi3;
  logic [7:0] rx3;
  logic [2:0] cs3_n;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_done = 0;

  logic [7:0] s_tx, s_word;
  logic       s_first, s_cpol, s_cpha;
  int         s_idx, s_nsamp;
  logic       s_prev_act, s_prev_clk;

  spi_master_cfg #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .busy(busy), .done(done),
    .rx_data(rx_data), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
  );

  spi_master_cfg #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .tx_data(tx_data), .cs_sel(cs_sel3),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .busy(busy3), .done(done3),
    .rx_data(rx3), .spi_clk(sclk3), .spi_mosi(mosi3), .spi_miso(1'b1),
    .spi_cs_n(cs3_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Slave: drives MISO MSB first, samples MOSI, edge roles taken from the mode it was told.
  always @(negedge clk) begin
    logic act, lead;
    if (!rst_n) begin
      spi_miso   = 1'b0;
      s_prev_act = 1'b0;
      s_prev_clk = 1'b0;
    end else begin
      act = ~&spi_cs_n;
      if (act && !s_prev_act) begin
        check_eq("sclk_idle_at_cs", spi_clk, s_cpol);
        s_word  = 8'h00;
        s_nsamp = 0;
        s_idx   = 7;
        if (!s_cpha) begin
          spi_miso = s_tx[7];
          s_idx    = 6;
        end
      end else if (act && (spi_clk != s_prev_clk)) begin
        lead = (spi_clk != s_cpol);
        if (lead ^ s_cpha) begin
          if (s_nsamp == 0) s_first = spi_mosi;
          s_word = {s_word[6:0], spi_mosi};
          s_nsamp++;
        end else if (s_idx >= 0) begin
          spi_miso = s_tx[s_idx];
          s_idx--;
        end
      end
      s_prev_act = act;
      s_prev_clk = spi_clk;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      n_done++;
      check_eq("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("rx_data", rx_data, e.rx);
        check_eq("mosi_word", s_word, e.wire_w);
        check_eq("mosi_first", s_first, e.first);
        check_eq("slave_samples", s_nsamp, 8);
      end
    end
  end

  task automatic start_xfer(input logic [7:0] tx, input logic [1:0] cs, input logic pol,
                            input logic pha, input logic lsb, input logic [7:0] stx, input bit now);
    exp_t e;
    logic eff_lsb;
    if (!now) @(negedge clk);
`ifdef SPI_MASTER_LSB_FIRST_EN
    eff_lsb = lsb;
`else
    eff_lsb = 1'b0;
`endif
    s_tx = stx; s_cpol = pol; s_cpha = pha;
    tx_data = tx; cs_sel = cs; cpol = pol; cpha = pha; lsb_first = lsb;
    e.wire_w = eff_lsb ? rev8(tx) : tx;
    e.first  = e.wire_w[7];
    e.rx     = eff_lsb ? rev8(stx) : stx;
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      @(negedge clk);
      i++;
    end
    check_eq("done_in_time", done, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, want finish before 300us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   nd0, b_first, b_last, c_first, c_last, d_cyc, i;
    logic mosi1, cs3_ok;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; tx_data = '0; cs_sel = '0; cs_sel3 = 2'd3;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    s_tx = '0; s_cpol = 1'b0; s_cpha = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cs_n", spi_cs_n, 4'hF);
    check_eq("rst_sclk", spi_clk, 0);
    check_eq("rst_mosi", spi_mosi, 0);
    check_eq("rst_rx", rx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0 frame with cycle-accurate handshake timing
    start_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
    b_first = 0; b_last = 0; c_first = 0; c_last = 0; d_cyc = 0; mosi1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) mosi1 = spi_mosi;
      if (busy) begin
        if (b_first == 0) b_first = c;
        b_last = c;
      end
      if (!spi_cs_n[0]) begin
        if (c_first == 0) c_first = c;
        c_last = c;
      end
      if (done && d_cyc == 0) d_cyc = c;
    end
    check_eq("t1_mosi_cycle1", mosi1, 1);
    check_eq("t1_busy_first", b_first, 1);
    check_eq("t1_busy_last", b_last, 34);
    check_eq("t1_cs_first", c_first, 1);
    check_eq("t1_cs_last", c_last, 34);
    check_eq("t1_done_cycle", d_cyc, 35);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      start_xfer(8'h5A, 2'd0, m[1], m[0], 1'b0, 8'hC3, 1'b0);
      wait_done(100);
      repeat (3) @(negedge clk);
      check_eq("idle_sclk_cpol", spi_clk, m[1]);
    end

    // start during busy is ignored
    nd0 = n_done;
    start_xfer(8'h96, 2'd0, 1'b0, 1'b1, 1'b0, 8'h69, 1'b0);
    repeat (4) @(negedge clk);
    tx_data = 8'hFF; cpha = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    repeat (40) @(negedge clk);
    check_eq("t3_one_done", n_done - nd0, 1);
    check_eq("t3_idle_busy", busy, 0);

    // Reset mid-transfer
    nd0 = n_done;
    start_xfer(8'h3C, 2'd0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t4_cs_n", spi_cs_n, 4'hF);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_sclk", spi_clk, 0);
    check_eq("t4_rx", rx_data, 0);
    sb.delete(sb.size() - 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t4_no_done", n_done - nd0, 0);
    start_xfer(8'hC3, 2'd0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
    wait_done(100);

    // Chip select decode and back-to-back transfer
    start_xfer(8'h11, 2'd2, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0);
    @(negedge clk);
    check_eq("t5_cs_sel2", spi_cs_n, 4'b1011);
    wait_done(100);
    check_eq("t5_cs_gap", spi_cs_n, 4'hF);
    start_xfer(8'h33, 2'd3, 1'b0, 1'b0, 1'b0, 8'h44, 1'b1);
    @(negedge clk);
    check_eq("t5_cs_sel3", spi_cs_n, 4'b0111);
    wait_done(100);

    // Out-of-range select on a 3-line instance
    @(negedge clk);
    tx_data = 8'h5A; cpol = 1'b0; cpha = 1'b0; cs_sel3 = 2'd3; start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    cs3_ok = 1'b1;
    i = 0;
    while (!done3 && i < 100) begin
      @(negedge clk);
      if (cs3_n != 3'b111) cs3_ok = 1'b0;
      i++;
    end
    check_eq("t5_cs3_none", cs3_ok, 1);
    check_eq("t5_done3", done3, 1);
    check_eq("t5_rx3", rx3, 8'hFF);

    // Bit order
    start_xfer(8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
    wait_done(100);

    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
